// File: rtl/exe_stage_mdu.sv
// Execute stage: ID->EXE register, prioritised forwarding, one-hot ALU and an
// iterative restoring divider. alu_op: 0 add 1 sub 2 slt 3 sltu 4 and 5 nor 6 or 7 xor 8 sll 9 srl 10 sra 11 lui
module exe_stage_mdu #(
  parameter int              XLEN     = 32,
  parameter int              NFWD     = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h1c000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 ds_to_es_valid,
  output logic                 es_allow_in,
  input  logic [XLEN-1:0]      ds_pc,
  input  logic [11:0]          ds_alu_op,
  input  logic                 ds_div_en,
  input  logic                 ds_div_signed,
  input  logic                 ds_div_mod,
  input  logic [XLEN-1:0]      ds_src1,
  input  logic [XLEN-1:0]      ds_src2,
  input  logic [4:0]           ds_raddr1,
  input  logic [4:0]           ds_raddr2,
  input  logic                 ds_sram_en,
  input  logic [3:0]           ds_sram_we,
  input  logic [3:0]           ds_rf_we,
  input  logic [4:0]           ds_rf_waddr,
  input  logic [4*NFWD-1:0]    fwd_we,
  input  logic [5*NFWD-1:0]    fwd_waddr,
  input  logic [XLEN*NFWD-1:0] fwd_wdata,
  input  logic                 ms_allow_in,
  output logic                 es_to_ms_valid,
  output logic [XLEN-1:0]      es_pc,
  output logic                 es_sram_en,
  output logic [3:0]           es_sram_we,
  output logic [XLEN-1:0]      es_sram_addr,
  output logic [XLEN-1:0]      es_sram_wdata,
  output logic [3:0]           es_rf_we,
  output logic [4:0]           es_rf_waddr,
  output logic [XLEN-1:0]      es_rf_wdata,
  output logic                 es_busy
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  logic            es_valid;
  logic            es_ready_go;
  logic [XLEN-1:0] pc_r, src1_r, src2_r;
  logic [11:0]     alu_op_r;
  logic            div_en_r, div_signed_r, div_mod_r;
  logic [4:0]      raddr1_r, raddr2_r, rf_waddr_r;
  logic            sram_en_r;
  logic [3:0]      sram_we_r, rf_we_r;

  div_state_t      div_state;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] quo, rem, divisor;
  logic            neg_q, neg_r, div_zero;

  logic [XLEN-1:0] op1, op2, alu_result;
  logic [SHW-1:0]  sa;
  logic            sign1, sign2;
  logic [XLEN-1:0] mag1, mag2, q_fix, r_fix, div_result;
  logic [XLEN:0]   shifted, trial;

  assign es_ready_go    = !div_en_r || (div_state == DIV_DONE);
  assign es_allow_in    = !es_valid || (es_ready_go && ms_allow_in);
  assign es_to_ms_valid = es_valid && es_ready_go;

  always_ff @(posedge clk) begin
    if (!reset) begin
      es_valid     <= 1'b0;
      pc_r         <= RESET_PC;
      alu_op_r     <= '0;
      div_en_r     <= 1'b0;
      div_signed_r <= 1'b0;
      div_mod_r    <= 1'b0;
      src1_r       <= '0;
      src2_r       <= '0;
      raddr1_r     <= '0;
      raddr2_r     <= '0;
      sram_en_r    <= 1'b0;
      sram_we_r    <= '0;
      rf_we_r      <= '0;
      rf_waddr_r   <= '0;
    end else begin
      if (flush)
        es_valid <= 1'b0;
      else if (es_allow_in)
        es_valid <= ds_to_es_valid;
      if (es_allow_in) begin
        pc_r         <= ds_pc;
        alu_op_r     <= ds_alu_op;
        div_en_r     <= ds_div_en;
        div_signed_r <= ds_div_signed;
        div_mod_r    <= ds_div_mod;
        src1_r       <= ds_src1;
        src2_r       <= ds_src2;
        raddr1_r     <= ds_raddr1;
        raddr2_r     <= ds_raddr2;
        sram_en_r    <= ds_sram_en;
        sram_we_r    <= ds_sram_we;
        rf_we_r      <= ds_rf_we;
        rf_waddr_r   <= ds_rf_waddr;
      end
    end
  end

  // Walk from the oldest source down so the youngest matching source wins.
  always_comb begin
    op1 = src1_r;
    op2 = src2_r;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_we[4*i +: 4] != 4'b0 && fwd_waddr[5*i +: 5] != 5'd0 && fwd_waddr[5*i +: 5] == raddr1_r)
        op1 = fwd_wdata[XLEN*i +: XLEN];
      if (fwd_we[4*i +: 4] != 4'b0 && fwd_waddr[5*i +: 5] != 5'd0 && fwd_waddr[5*i +: 5] == raddr2_r)
        op2 = fwd_wdata[XLEN*i +: XLEN];
    end
  end

  assign sa = op2[SHW-1:0];

  always_comb begin
    alu_result = '0;
    if (alu_op_r[0])       alu_result = op1 + op2;
    else if (alu_op_r[1])  alu_result = op1 - op2;
    else if (alu_op_r[2])  alu_result = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
    else if (alu_op_r[3])  alu_result = {{(XLEN-1){1'b0}}, op1 < op2};
    else if (alu_op_r[4])  alu_result = op1 & op2;
    else if (alu_op_r[5])  alu_result = ~(op1 | op2);
    else if (alu_op_r[6])  alu_result = op1 | op2;
    else if (alu_op_r[7])  alu_result = op1 ^ op2;
    else if (alu_op_r[8])  alu_result = op1 << sa;
    else if (alu_op_r[9])  alu_result = op1 >> sa;
    else if (alu_op_r[10]) alu_result = $signed(op1) >>> sa;
    else if (alu_op_r[11]) alu_result = op2;
  end

  assign sign1   = div_signed_r && op1[XLEN-1];
  assign sign2   = div_signed_r && op2[XLEN-1];
  assign mag1    = sign1 ? ('0 - op1) : op1;
  assign mag2    = sign2 ? ('0 - op2) : op2;
  assign shifted = {rem, quo[XLEN-1]};
  assign trial   = shifted - {1'b0, divisor};

  // Dividend magnitude shifts out of quo into rem while quotient bits shift in.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_state <= DIV_IDLE;
      cnt       <= '0;
      quo       <= '0;
      rem       <= '0;
      divisor   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      unique case (div_state)
        DIV_IDLE: begin
          if (es_valid && div_en_r && !flush) begin
            div_state <= DIV_BUSY;
            cnt       <= '0;
            quo       <= mag1;
            rem       <= '0;
            divisor   <= mag2;
            neg_q     <= sign1 ^ sign2;
            neg_r     <= sign1;
            div_zero  <= (op2 == '0);
          end
        end
        DIV_BUSY: begin
          if (flush) begin
            div_state <= DIV_IDLE;
          end else begin
            if (!trial[XLEN]) begin
              rem <= trial[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= shifted[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (cnt == SHW'(XLEN - 1))
              div_state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (flush || ms_allow_in)
            div_state <= DIV_IDLE;
        end
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

  assign q_fix      = div_zero ? '1 : (neg_q ? ('0 - quo) : quo);
  assign r_fix      = neg_r ? ('0 - rem) : rem;
  assign div_result = div_mod_r ? r_fix : q_fix;

  assign es_pc         = pc_r;
  assign es_sram_en    = sram_en_r && es_valid;
  assign es_sram_we    = es_valid ? sram_we_r : 4'b0;
  assign es_sram_addr  = alu_result;
  assign es_sram_wdata = op2;
  assign es_rf_we      = es_valid ? rf_we_r : 4'b0;
  assign es_rf_waddr   = rf_waddr_r;
  assign es_rf_wdata   = div_en_r ? div_result : alu_result;
  assign es_busy       = (div_state == DIV_BUSY);

endmodule
